// File: rtl/romulusn_tag_out_if.sv
// Tag-word handshake bundle for the Romulus-N tag output/verify stage.
// The master modport is the tag block; the slave modport is the surrounding core/link.
interface romulusn_tag_out_if;
  logic [31:0] do_data;
  logic        do_valid;
  logic        do_ready;
  logic        do_last;
  logic [31:0] tag_in;
  logic        tag_valid;
  logic        tag_ready;

  modport master (
    output do_data, do_valid, do_last, tag_ready,
    input  do_ready, tag_in, tag_valid
  );

  modport slave (
    input  do_data, do_valid, do_last, tag_ready,
    output do_ready, tag_in, tag_valid
  );
endinterface

// File: rtl/romulusn_tag_out.sv
// Romulus-N tag output/verify stage: snapshots the final state on start, then
// streams G(S) word by word (encrypt) or compares it against a received tag in constant time (decrypt).
module romulusn_tag_out #(
  parameter int unsigned WORDS   = 4,
  parameter bit          APPLY_G = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [127:0]        state,
  input  logic                start,
  input  logic                decrypt,
  romulusn_tag_out_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                tag_ok
);

  if (WORDS < 1 || WORDS > 4) begin : g_bad_words
    $error("romulusn_tag_out: WORDS must be in 1..4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_VERIFY,
    S_DONE
  } state_e;

  localparam logic [2:0] LAST_CNT = 3'(WORDS - 1);

  state_e       st_q, st_d;
  logic [127:0] sr_q, sr_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         mismatch_q, mismatch_d;
  logic         verify_q, verify_d;
  logic         tag_ok_q, tag_ok_d;

  logic [31:0]  top_word;
  logic         last_word;
  logic         do_hs;
  logic         tag_hs;

  logic [31:0]  do_data_o;
  logic         do_valid_o;
  logic         do_last_o;
  logic         tag_ready_o;
  logic         busy_o;
  logic         done_o;

  // G per byte: rotate right by one, with the new MSB being b[0]^b[7].
  function automatic logic [31:0] g_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      r[8*i +: 8] = {w[8*i] ^ w[8*i+7], w[8*i+1 +: 7]};
    end
    return r;
  endfunction

  assign top_word  = APPLY_G ? g_word(sr_q[127:96]) : sr_q[127:96];
  assign last_word = (cnt_q == LAST_CNT);
  assign do_hs     = (st_q == S_EMIT)   && bus.do_ready;
  assign tag_hs    = (st_q == S_VERIFY) && bus.tag_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      verify_q   <= 1'b0;
      tag_ok_q   <= 1'b0;
    end else begin
      st_q       <= st_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      verify_q   <= verify_d;
      tag_ok_q   <= tag_ok_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    mismatch_d = mismatch_q;
    verify_d   = verify_q;
    tag_ok_d   = tag_ok_q;
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          sr_d       = state;
          cnt_d      = '0;
          mismatch_d = 1'b0;
          verify_d   = decrypt;
          tag_ok_d   = 1'b0;
          st_d       = decrypt ? S_VERIFY : S_EMIT;
        end
      end
      S_EMIT: begin
        if (do_hs) begin
          sr_d  = sr_q << 32;
          cnt_d = cnt_q + 3'd1;
          if (last_word) st_d = S_DONE;
        end
      end
      S_VERIFY: begin
        // Mismatches only accumulate; all WORDS words are always consumed.
        if (tag_hs) begin
          mismatch_d = mismatch_q | (bus.tag_in != top_word);
          sr_d       = sr_q << 32;
          cnt_d      = cnt_q + 3'd1;
          if (last_word) st_d = S_DONE;
        end
      end
      S_DONE: begin
        tag_ok_d = verify_q & ~mismatch_q;
        st_d     = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    do_data_o   = '0;
    do_valid_o  = 1'b0;
    do_last_o   = 1'b0;
    tag_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (st_q)
      S_EMIT: begin
        do_data_o  = top_word;
        do_valid_o = 1'b1;
        do_last_o  = last_word;
        busy_o     = 1'b1;
      end
      S_VERIFY: begin
        tag_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.do_data   = do_data_o;
  assign bus.do_valid  = do_valid_o;
  assign bus.do_last   = do_last_o;
  assign bus.tag_ready = tag_ready_o;
  assign busy          = busy_o;
  assign done          = done_o;
  assign tag_ok        = tag_ok_q;

endmodule

// File: tb/tb_romulusn_tag_out.sv
// Directed self-checking bench for romulusn_tag_out: emit, backpressure,
// verify pass/fail, control corner cases and the raw-state debug build.
module tb_romulusn_tag_out;

  localparam logic [127:0] E_STATE = {32'h018000FF, 96'h0};
  localparam logic [127:0] V_STATE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state;
  logic         start;
  logic         decrypt;
  logic         busy, done, tag_ok;

  logic         start2;
  logic         busy_raw, done_raw, tag_ok_raw;

  int passed = 0;
  int total  = 0;

  romulusn_tag_out_if bus ();
  romulusn_tag_out_if braw ();

  romulusn_tag_out #(.WORDS(4), .APPLY_G(1'b1)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .start   (start),
    .decrypt (decrypt),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done),
    .tag_ok  (tag_ok)
  );

  romulusn_tag_out #(.WORDS(2), .APPLY_G(1'b0)) u_raw (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .start   (start2),
    .decrypt (1'b0),
    .bus     (braw.master),
    .busy    (busy_raw),
    .done    (done_raw),
    .tag_ok  (tag_ok_raw)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a full verify transaction with gaps in tag_valid; no checking here.
  task automatic run_verify(input logic [31:0] flip, output int done_at,
                            output logic ok_at_start, output logic ok_final,
                            output logic no_do_valid);
    logic [31:0] w [4] = '{32'h8091A2B3, 32'h44556677, 32'hFFEEDDCC, 32'h3B2A1908};
    bit          vpat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int          k = 0;
    done_at = -1;
    state = V_STATE; decrypt = 1'b1; start = 1'b1; bus.do_ready = 1'b1;
    tick();
    start = 1'b0; decrypt = 1'b0;
    state = '1;
    ok_at_start = tag_ok;
    no_do_valid = ~bus.do_valid;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        done_at = c;
        break;
      end
      if ((c >= 6 || vpat[c]) && k < 4) begin
        bus.tag_valid = 1'b1;
        bus.tag_in    = (k == 0) ? (w[k] ^ flip) : w[k];
        if (bus.tag_ready) k++;
      end else begin
        bus.tag_valid = 1'b0;
        bus.tag_in    = 32'hBADBAD00;
      end
      tick();
    end
    bus.tag_valid = 1'b0;
    bus.do_ready  = 1'b0;
    tick();
    ok_final = tag_ok;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (bus.do_valid !== 1'b0) $display("FAIL reset_do_valid got=%b exp=0", bus.do_valid); else passed++;
    total++; if (bus.do_data !== 32'h0) $display("FAIL reset_do_data got=%h exp=00000000", bus.do_data); else passed++;
    total++; if (bus.tag_ready !== 1'b0) $display("FAIL reset_tag_ready got=%b exp=0", bus.tag_ready); else passed++;
    total++; if ({done, tag_ok} !== 2'b00) $display("FAIL reset_done_tag_ok got=%b exp=00", {done, tag_ok}); else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_emit();
    logic [31:0] exp [4] = '{32'h80C0007F, 32'h0, 32'h0, 32'h0};
    state = E_STATE; decrypt = 1'b0; start = 1'b1; bus.do_ready = 1'b1;
    tick();
    start = 1'b0;
    state = V_STATE;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.do_valid !== 1'b1) $display("FAIL emit_valid[%0d] got=%b exp=1", i, bus.do_valid); else passed++;
      total++; if (bus.do_data !== exp[i]) $display("FAIL emit_data[%0d] got=%h exp=%h", i, bus.do_data, exp[i]); else passed++;
      total++; if (bus.do_last !== (i == 3)) $display("FAIL emit_last[%0d] got=%b exp=%b", i, bus.do_last, (i == 3)); else passed++;
      tick();
    end
    total++; if (done !== 1'b1) $display("FAIL emit_done got=%b exp=1", done); else passed++;
    total++; if ({busy, bus.do_valid} !== 2'b00) $display("FAIL emit_busy_after got=%b exp=00", {busy, bus.do_valid}); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL emit_done_pulse got=%b exp=0", done); else passed++;
    total++; if (tag_ok !== 1'b0) $display("FAIL emit_tag_ok got=%b exp=0", tag_ok); else passed++;
    bus.do_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [4] = '{32'h80C0007F, 32'h0, 32'h0, 32'h0};
    int k = 0;
    bit seen_done = 1'b0;
    bit bad_data  = 1'b0;
    state = E_STATE; decrypt = 1'b0; start = 1'b1; bus.do_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      bus.do_ready = c[0];
      if (bus.do_valid) begin
        if (k > 3 || bus.do_data !== exp[k] || bus.do_last !== (k == 3)) bad_data = 1'b1;
        if (c[0]) k++;
      end
      tick();
    end
    bus.do_ready = 1'b0;
    total++; if (bad_data) $display("FAIL bp_data_stable got=corrupt exp=in-order-held"); else passed++;
    total++; if (k !== 4) $display("FAIL bp_handshakes got=%0d exp=4", k); else passed++;
    total++; if (!seen_done) $display("FAIL bp_done got=timeout exp=done"); else passed++;
    tick();
  endtask

  task automatic test_verify_pass();
    int   done_at;
    logic ok_start, ok_final, no_dv;
    run_verify(32'h0, done_at, ok_start, ok_final, no_dv);
    total++; if (no_dv !== 1'b1) $display("FAIL vpass_do_valid_in_verify got=%b exp=1", no_dv); else passed++;
    total++; if (done_at !== 6) $display("FAIL vpass_done_cycle got=%0d exp=6", done_at); else passed++;
    total++; if (ok_final !== 1'b1) $display("FAIL vpass_tag_ok got=%b exp=1", ok_final); else passed++;
    tick(); tick();
    total++; if (tag_ok !== 1'b1) $display("FAIL vpass_tag_ok_held got=%b exp=1", tag_ok); else passed++;
  endtask

  task automatic test_verify_fail();
    int   done_at;
    logic ok_start, ok_final, no_dv;
    run_verify(32'h1, done_at, ok_start, ok_final, no_dv);
    total++; if (done_at !== 6) $display("FAIL vfail_done_cycle got=%0d exp=6", done_at); else passed++;
    total++; if (ok_final !== 1'b0) $display("FAIL vfail_tag_ok got=%b exp=0", ok_final); else passed++;
  endtask

  task automatic test_control();
    state = V_STATE; decrypt = 1'b0; start = 1'b1; bus.do_ready = 1'b1;
    tick();
    total++; if (tag_ok !== 1'b0) $display("FAIL ctrl_tag_ok_cleared_on_start got=%b exp=0", tag_ok); else passed++;
    total++; if (bus.do_data !== 32'h8091A2B3) $display("FAIL ctrl_word0 got=%h exp=8091A2B3", bus.do_data); else passed++;
    decrypt = 1'b1; state = '0; bus.tag_valid = 1'b1;
    tick();
    total++; if (bus.do_data !== 32'h44556677) $display("FAIL ctrl_start_ignored got=%h exp=44556677", bus.do_data); else passed++;
    total++; if ({busy, bus.tag_ready} !== 2'b10) $display("FAIL ctrl_still_emit got=%b exp=10", {busy, bus.tag_ready}); else passed++;
    tick();
    start = 1'b0; decrypt = 1'b0; bus.tag_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++; if ({busy, bus.do_valid, done, tag_ok} !== 4'b0000) $display("FAIL ctrl_async_reset got=%b exp=0000", {busy, bus.do_valid, done, tag_ok}); else passed++;
    total++; if (bus.do_data !== 32'h0) $display("FAIL ctrl_reset_data got=%h exp=00000000", bus.do_data); else passed++;
    tick();
    rst = 1'b1;
    tick();
    state = V_STATE; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (bus.do_data !== 32'h8091A2B3 || bus.do_last !== 1'b0) $display("FAIL ctrl_restart got=%h/%b exp=8091A2B3/0", bus.do_data, bus.do_last); else passed++;
    for (int i = 0; i < 4; i++) tick();
    total++; if (done !== 1'b1) $display("FAIL ctrl_restart_done got=%b exp=1", done); else passed++;
    bus.do_ready = 1'b0;
    tick();
  endtask

  task automatic test_raw();
    state = 128'h018000FF_DEADBEEF_12345678_9ABCDEF0; start2 = 1'b1; braw.do_ready = 1'b1;
    tick();
    start2 = 1'b0;
    total++; if (braw.do_data !== 32'h018000FF || braw.do_last !== 1'b0) $display("FAIL raw_word0 got=%h/%b exp=018000FF/0", braw.do_data, braw.do_last); else passed++;
    total++; if ({busy_raw, braw.tag_ready} !== 2'b10) $display("FAIL raw_busy got=%b exp=10", {busy_raw, braw.tag_ready}); else passed++;
    tick();
    total++; if (braw.do_data !== 32'hDEADBEEF || braw.do_last !== 1'b1) $display("FAIL raw_word1_last got=%h/%b exp=DEADBEEF/1", braw.do_data, braw.do_last); else passed++;
    tick();
    total++; if ({done_raw, braw.do_valid} !== 2'b10) $display("FAIL raw_done got=%b exp=10", {done_raw, braw.do_valid}); else passed++;
    tick();
    total++; if (tag_ok_raw !== 1'b0) $display("FAIL raw_tag_ok got=%b exp=0", tag_ok_raw); else passed++;
    braw.do_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; state = '0; start = 1'b0; decrypt = 1'b0; start2 = 1'b0;
    bus.do_ready = 1'b0; bus.tag_in = '0; bus.tag_valid = 1'b0;
    braw.do_ready = 1'b0; braw.tag_in = '0; braw.tag_valid = 1'b0;
    test_reset();
    test_emit();
    test_backpressure();
    test_verify_fail();
    test_verify_pass();
    test_control();
    test_raw();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
